// File: rtl/axis_intra_cycle_realign.sv
// Receive-side realigner: finds the first over-threshold sample and shifts the frame to lane 0.
// Optional counters: define AXIS_INTRA_CYCLE_REALIGN_STATS_EN.
module axis_intra_cycle_realign #(
  parameter int DATA_WIDTH       = 256,
  parameter int SAMPLE_PER_CYCLE = 16,
  parameter int SAMPLE_WIDTH     = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [15:0]           threshold,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic                  s_axis_tvalid,
  input  logic                  s_axis_tlast,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tvalid,
  output logic                  m_axis_tlast,
  output logic [15:0]           detected_offset,
  output logic                  offset_locked
`ifdef AXIS_INTRA_CYCLE_REALIGN_STATS_EN
  ,
  output logic [31:0]           frames_aligned_count,
  output logic [31:0]           frames_dropped_count,
  output logic [15:0]           last_search_beats
`endif
);

  localparam int KW = (SAMPLE_PER_CYCLE > 1) ? $clog2(SAMPLE_PER_CYCLE) : 1;

  typedef enum logic [1:0] {SEARCH, ALIGN, FLUSH} state_t;

  state_t                  state_q, state_d;
  logic [DATA_WIDTH-1:0]   hold_q, hold_d;
  logic [KW-1:0]           k_q, k_d;
  logic [15:0]             offset_d;
  logic                    locked_d, valid_d, last_d;
  logic [DATA_WIDTH-1:0]   data_d;

  logic                    any_hit;
  logic [KW-1:0]           hit_idx;
  logic [SAMPLE_WIDTH-1:0] smp, mag;
  logic                    load;

  logic [DATA_WIDTH-1:0]   upper;
  logic [2*DATA_WIDTH-1:0] cat;
  logic [DATA_WIDTH-1:0]   cand [SAMPLE_PER_CYCLE];
  logic [DATA_WIDTH-1:0]   shifted;

  // Scan high to low so the lowest hitting lane wins.
  always_comb begin
    any_hit = 1'b0;
    hit_idx = '0;
    smp     = '0;
    mag     = '0;
    for (int j = SAMPLE_PER_CYCLE - 1; j >= 0; j--) begin
      smp = s_axis_tdata[j*SAMPLE_WIDTH +: SAMPLE_WIDTH];
      if (!smp[SAMPLE_WIDTH-1])
        mag = smp;
      else if (smp == {1'b1, {(SAMPLE_WIDTH-1){1'b0}}})
        mag = {1'b0, {(SAMPLE_WIDTH-1){1'b1}}};
      else
        mag = -smp;
      if (mag >= threshold) begin
        any_hit = 1'b1;
        hit_idx = KW'(j);
      end
    end
  end

  assign load = (state_q != ALIGN) && s_axis_tvalid && any_hit;

  // Flush shifts in zeros; align shifts in the new beat.
  assign upper = (state_q == FLUSH) ? '0 : s_axis_tdata;
  assign cat   = {upper, hold_q};

  always_comb begin
    for (int kk = 0; kk < SAMPLE_PER_CYCLE; kk++)
      cand[kk] = cat[kk*SAMPLE_WIDTH +: DATA_WIDTH];
    shifted = cand[k_q];
  end

  always_comb begin
    state_d  = state_q;
    hold_d   = hold_q;
    k_d      = k_q;
    offset_d = detected_offset;
    locked_d = offset_locked;
    valid_d  = 1'b0;
    last_d   = 1'b0;
    data_d   = '0;
    unique case (state_q)
      SEARCH: ;
      ALIGN: begin
        if (s_axis_tvalid) begin
          data_d  = shifted;
          valid_d = 1'b1;
          hold_d  = s_axis_tdata;
          if (s_axis_tlast) state_d = FLUSH;
        end
      end
      FLUSH: begin
        data_d   = shifted;
        valid_d  = 1'b1;
        last_d   = 1'b1;
        state_d  = SEARCH;
        locked_d = 1'b0;
      end
      default: state_d = SEARCH;
    endcase
    // A hit in FLUSH overrides the return to SEARCH; flush data already used old hold/k.
    if (load) begin
      hold_d   = s_axis_tdata;
      k_d      = hit_idx;
      offset_d = 16'(hit_idx);
      locked_d = 1'b1;
      state_d  = s_axis_tlast ? FLUSH : ALIGN;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= SEARCH;
      hold_q          <= '0;
      k_q             <= '0;
      m_axis_tdata    <= '0;
      m_axis_tvalid   <= 1'b0;
      m_axis_tlast    <= 1'b0;
      detected_offset <= '0;
      offset_locked   <= 1'b0;
    end else begin
      state_q         <= state_d;
      hold_q          <= hold_d;
      k_q             <= k_d;
      m_axis_tdata    <= data_d;
      m_axis_tvalid   <= valid_d;
      m_axis_tlast    <= last_d;
      detected_offset <= offset_d;
      offset_locked   <= locked_d;
    end
  end

`ifdef AXIS_INTRA_CYCLE_REALIGN_STATS_EN
  logic [15:0] search_cnt;
  logic        discard;

  assign discard = (state_q != ALIGN) && s_axis_tvalid && !any_hit;

  always_ff @(posedge clk) begin
    if (rst) begin
      frames_aligned_count <= '0;
      frames_dropped_count <= '0;
      last_search_beats    <= '0;
      search_cnt           <= '0;
    end else begin
      if (state_q == FLUSH)
        frames_aligned_count <= frames_aligned_count + 32'd1;
      if (discard && s_axis_tlast)
        frames_dropped_count <= frames_dropped_count + 32'd1;
      if (discard && search_cnt != 16'hFFFF)
        search_cnt <= search_cnt + 16'd1;
      if (load) begin
        last_search_beats <= search_cnt;
        search_cnt        <= '0;
      end
    end
  end
`endif

endmodule

// File: tb/tb_axis_intra_cycle_realign.sv
// Bench for axis_intra_cycle_realign: directed cases plus random frames
// against a sample-queue reference model.
module tb_axis_intra_cycle_realign;
  localparam int DW  = 256;
  localparam int SPC = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic [15:0]   threshold;
  logic [DW-1:0] s_axis_tdata;
  logic          s_axis_tvalid;
  logic          s_axis_tlast;
  logic [DW-1:0] m_axis_tdata;
  logic          m_axis_tvalid;
  logic          m_axis_tlast;
  logic [15:0]   detected_offset;
  logic          offset_locked;
`ifdef AXIS_INTRA_CYCLE_REALIGN_STATS_EN
  logic [31:0]   frames_aligned_count;
  logic [31:0]   frames_dropped_count;
  logic [15:0]   last_search_beats;
`endif

  axis_intra_cycle_realign dut (
    .clk             (clk),
    .rst             (rst),
    .threshold       (threshold),
    .s_axis_tdata    (s_axis_tdata),
    .s_axis_tvalid   (s_axis_tvalid),
    .s_axis_tlast    (s_axis_tlast),
    .m_axis_tdata    (m_axis_tdata),
    .m_axis_tvalid   (m_axis_tvalid),
    .m_axis_tlast    (m_axis_tlast),
    .detected_offset (detected_offset),
    .offset_locked   (offset_locked)
`ifdef AXIS_INTRA_CYCLE_REALIGN_STATS_EN
    ,
    .frames_aligned_count (frames_aligned_count),
    .frames_dropped_count (frames_dropped_count),
    .last_search_beats    (last_search_beats)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DW-1:0] d;
    bit            last;
    int            due;
  } exp_t;

  int   tests = 0;
  int   fails = 0;
  int   cyc   = 0;
  exp_t expq[$];
  int   cur[$];
  bit   open = 0;
  bit   fin;
  int   exp_off = 0;
  int   aligned_n = 0;
  int   dropped_n = 0;

  task automatic check(string tag, logic [DW-1:0] got, logic [DW-1:0] want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s @cyc %0d: got %h want %h", tag, cyc, got, want);
    end
  endtask

  function automatic int smpv(logic [DW-1:0] d, int j);
    return int'($signed(d[j*16 +: 16]));
  endfunction

  function automatic bit is_hit(int s, int thr);
    int m;
    m = (s < 0) ? -s : s;
    if (m > 32767) m = 32767;
    return m >= thr;
  endfunction

  function automatic logic [DW-1:0] ramp(int base, int lo);
    logic [DW-1:0] r;
    for (int j = 0; j < SPC; j++)
      r[j*16 +: 16] = (j < lo) ? 16'd0 : 16'(base + j);
    return r;
  endfunction

  task automatic emit(bit last, int due);
    exp_t e;
    e.d = '0;
    for (int j = 0; j < SPC; j++) e.d[j*16 +: 16] = 16'(cur.pop_front());
    e.last = last;
    e.due  = due;
    expq.push_back(e);
  endtask

  task automatic finish_frame();
    while (cur.size() < SPC) cur.push_back(0);
    emit(1'b1, cyc + 1);
    open = 0;
    fin  = 1;
    aligned_n++;
  endtask

  task automatic model(logic [DW-1:0] d, bit l);
    int k;
    if (!open) begin
      k = -1;
      for (int j = 0; j < SPC; j++)
        if (k < 0 && is_hit(smpv(d, j), int'(threshold))) k = j;
      if (k < 0) begin
        if (l) dropped_n++;
      end else begin
        exp_off = k;
        open    = 1;
        cur.delete();
        for (int j = k; j < SPC; j++) cur.push_back(smpv(d, j));
        if (l) finish_frame();
      end
    end else begin
      for (int j = 0; j < SPC; j++) cur.push_back(smpv(d, j));
      emit(1'b0, cyc);
      if (l) finish_frame();
    end
  endtask

  task automatic step(bit v, logic [DW-1:0] d, bit l, bit r = 0);
    bit want_v;
    @(negedge clk);
    rst           = r;
    s_axis_tvalid = v;
    s_axis_tdata  = d;
    s_axis_tlast  = l;
    fin = 0;
    if (r) begin
      open = 0;
      cur.delete();
      expq.delete();
      exp_off   = 0;
      aligned_n = 0;
      dropped_n = 0;
    end else if (v) begin
      model(d, l);
    end
    @(posedge clk);
    #1;
    want_v = (expq.size() > 0) && (expq[0].due == cyc);
    check("tvalid", DW'(m_axis_tvalid), DW'(want_v));
    if (want_v) begin
      check("tdata", m_axis_tdata, expq[0].d);
      check("tlast", DW'(m_axis_tlast), DW'(expq[0].last));
      void'(expq.pop_front());
    end else begin
      check("idle_out", {m_axis_tdata, m_axis_tlast}, '0);
    end
    check("offset", DW'(detected_offset), DW'(exp_off));
    check("locked", DW'(offset_locked), DW'(open || fin));
    cyc++;
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) step(1'b0, {8{$urandom}}, 1'($urandom));
  endtask

  task automatic gap();
    if ($urandom % 3 == 0) idle(int'($urandom_range(1, 3)));
  endtask

  function automatic logic [DW-1:0] rbeat(int thr, int hitk);
    logic [DW-1:0] r;
    int v, m;
    for (int j = 0; j < SPC; j++) begin
      if (hitk < 0 || j < hitk)
        v = (thr > 1) ? int'($urandom_range(0, 2*(thr-1))) - (thr-1) : 0;
      else if (j == hitk) begin
        m = int'($urandom_range(thr, 32767));
        v = ($urandom % 2 == 0) ? m : -m;
        if (m == 32767 && v < 0 && $urandom % 2 == 0) v = -32768;
      end else
        v = int'($urandom);
      r[j*16 +: 16] = 16'(v);
    end
    return r;
  endfunction

  initial begin
    logic [DW-1:0] sat;
    int thr, nlead, nb, k;
    bit nohit;
    rst = 1'b1;
    threshold = 16'd100;
    s_axis_tdata = '0;
    s_axis_tvalid = 1'b0;
    s_axis_tlast = 1'b0;
    step(0, '0, 0, 1);
    step(0, '0, 0, 1);
    idle(2);

    // Basic realign, k = 5
    step(1, ramp(500, 5), 0);
    step(1, ramp(1000, 0), 0);
    step(1, ramp(1000, 0), 1);
    idle(2);
    // Leading zero beats then k = 0
    step(1, '0, 0);
    step(1, '0, 0);
    step(1, ramp(100, 0), 0);
    step(1, ramp(1100, 0), 1);
    idle(2);
    // Gap mid-frame, k = 9
    step(1, ramp(600, 9), 0);
    step(1, ramp(700, 0), 0);
    idle(4);
    step(1, ramp(800, 0), 1);
    idle(2);
    // Back-to-back: A k = 7, B k = 3 in A's flush cycle
    step(1, ramp(2000, 7), 0);
    step(1, ramp(3000, 0), 1);
    step(1, ramp(4000, 3), 0);
    step(1, ramp(5000, 0), 1);
    idle(2);
    // Hit on tlast beat, k = 12
    step(1, ramp(900, 12), 1);
    idle(2);
    // No-hit frame with tlast
    step(1, ramp(0, 0), 1);
    idle(2);
    // Saturated -32768 against the top thresholds
    sat = '0;
    sat[4*16 +: 16] = 16'h8000;
    threshold = 16'd32767;
    step(1, sat, 1);
    threshold = 16'd32768;
    step(1, sat, 1);
    idle(2);
    threshold = 16'd0;
    step(1, ramp(0, 0), 1);
    idle(2);
    threshold = 16'd100;
    // Reset during ALIGN
    step(1, ramp(600, 2), 0);
    step(1, ramp(700, 0), 0);
    step(0, '0, 0, 1);
    idle(3);

    for (int f = 0; f < 60; f++) begin
      thr = ($urandom % 10 == 0) ? 0 : int'($urandom_range(1, 20000));
      threshold = 16'(thr);
      nohit = (thr != 0) && ($urandom % 5 == 0);
      nlead = (thr == 0) ? 0 : int'($urandom_range(0, 2));
      for (int i = 0; i < nlead; i++) begin
        gap();
        step(1, rbeat(thr, -1), 0);
      end
      if (nohit) begin
        gap();
        step(1, rbeat(thr, -1), 1);
      end else begin
        nb = int'($urandom_range(1, 4));
        k  = int'($urandom_range(0, SPC - 1));
        for (int i = 0; i < nb; i++) begin
          gap();
          step(1, (i == 0) ? rbeat(thr, k) : {8{$urandom}}, i == nb - 1);
        end
      end
    end
    idle(4);
    check("drained", DW'(expq.size()), '0);
`ifdef AXIS_INTRA_CYCLE_REALIGN_STATS_EN
    check("aligned_cnt", DW'(frames_aligned_count), DW'(aligned_n));
    check("dropped_cnt", DW'(frames_dropped_count), DW'(dropped_n));
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
